// File: rtl/countdown_timer.sv
// Loadable down-counter with a clock prescaler, one-cycle expiry pulse and optional auto-reload.
// Load/stop/start strobes are prioritised in that order over the run/expiry logic.
module countdown_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] count_o,
    output logic             running_o,
    output logic             zero_o,
    output logic             done_o
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic [PS_W-1:0]  presc_q;
    logic             running_q;
    logic             done_q;

    logic tick;
    logic count_is_one;

    assign tick         = (presc_q == PS_LAST);
    assign count_is_one = (count_q == WIDTH'(1));

    always_ff @(posedge clock_i) begin
        done_q <= 1'b0;
        if (reset_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
        end else if (load_i) begin
            state_q   <= IDLE;
            count_q   <= load_value_i;
            reload_q  <= load_value_i;
            presc_q   <= '0;
            running_q <= 1'b0;
        end else if (stop_i) begin
            // Prescaler phase is held so a later resume continues mid-period.
            if (state_q == RUN) begin
                state_q   <= PAUSE;
                running_q <= 1'b0;
            end
        end else if (start_i && (state_q != RUN)) begin
            if (count_q != '0) begin
                state_q   <= RUN;
                running_q <= 1'b1;
                if (state_q == IDLE) begin
                    presc_q <= '0;
                end
            end
        end else if (state_q == RUN) begin
            if (!tick) begin
                presc_q <= presc_q + PS_W'(1);
            end else begin
                presc_q <= '0;
                if (count_q > WIDTH'(1)) begin
                    count_q <= count_q - WIDTH'(1);
                end else begin
                    // Expiry; a zero count here can only be a degenerate case, so just stop quietly.
                    done_q <= count_is_one;
                    if (auto_reload_i && count_is_one) begin
                        count_q <= reload_q;
                    end else begin
                        count_q   <= '0;
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign count_o   = count_q;
    assign running_o = running_q;
    assign zero_o    = (count_q == '0);
    assign done_o    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Drives three timers (PRESCALE 1, 2, 4) with shared stimulus and checks them against a
// remaining-cycles model of the timer, plus directed checks taken straight from the timing rules.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic        st  = 1'b0;
    logic        sp  = 1'b0;
    logic        ar  = 1'b0;
    logic [15:0] lv  = '0;

    logic [15:0] cnt [3];
    logic        run [3];
    logic        zer [3];
    logic        dn  [3];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            countdown_timer #(
                .WIDTH   (16),
                .PRESCALE(1 << gi)
            ) u_dut (
                .clock_i      (clk),
                .reset_i      (rst),
                .load_i       (ld),
                .load_value_i (lv),
                .start_i      (st),
                .stop_i       (sp),
                .auto_reload_i(ar),
                .count_o      (cnt[gi]),
                .running_o    (run[gi]),
                .zero_o       (zer[gi]),
                .done_o       (dn[gi])
            );
        end
    endgenerate

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: m_r is the number of running edges left until expiry; count is derived from it.
    int m_cnt [3];
    int m_rel [3];
    int m_r   [3];
    int m_st  [3];   // 0 idle, 1 run, 2 pause
    bit m_dn  [3];

    function automatic void model_edge(int k);
        int p = 1 << k;
        m_dn[k] = 1'b0;
        if (rst) begin
            m_cnt[k] = 0; m_rel[k] = 0; m_r[k] = 0; m_st[k] = 0;
        end else if (ld) begin
            m_cnt[k] = int'(lv); m_rel[k] = int'(lv); m_r[k] = int'(lv) * p; m_st[k] = 0;
        end else if (sp) begin
            if (m_st[k] == 1) m_st[k] = 2;
        end else if (st && m_st[k] != 1) begin
            if (m_cnt[k] != 0) begin
                if (m_st[k] == 0) m_r[k] = m_cnt[k] * p;
                m_st[k] = 1;
            end
        end else if (m_st[k] == 1) begin
            m_r[k] = m_r[k] - 1;
            if (m_r[k] == 0) begin
                m_dn[k] = 1'b1;
                if (ar) begin
                    m_cnt[k] = m_rel[k];
                    m_r[k]   = m_rel[k] * p;
                end else begin
                    m_cnt[k] = 0;
                    m_st[k]  = 0;
                end
            end else begin
                m_cnt[k] = (m_r[k] + p - 1) / p;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        cyc++;
    endtask

    task automatic do_load(input int v);
        ld = 1'b1;
        lv = 16'(v);
        tick();
        ld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({cnt[k], run[k], zer[k], dn[k]} !== {16'd0, 1'b0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL reset p=%0d got cnt=%0d run=%b zero=%b done=%b want cnt=0 run=0 zero=1 done=0",
                         1 << k, cnt[k], run[k], zer[k], dn[k]);
            end
        end
        $display("test_reset: outputs sampled after reset");
    endtask

    task automatic test_one_shot();
        ar = 1'b0;
        do_load(5);
        st = 1'b1;
        tick();
        st = 1'b0;
        $display("test_one_shot: load 5, start");
        for (int i = 1; i <= 6; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (cnt[k] !== 16'(m_cnt[k]) || run[k] !== (m_st[k] == 1) ||
                    zer[k] !== (m_cnt[k] == 0) || dn[k] !== m_dn[k]) begin
                    bad++;
                    $display("FAIL one_shot_model p=%0d cyc=%0d got cnt=%0d run=%b zero=%b done=%b want cnt=%0d run=%b zero=%b done=%b",
                             1 << k, cyc, cnt[k], run[k], zer[k], dn[k], m_cnt[k], m_st[k] == 1, m_cnt[k] == 0, m_dn[k]);
                end
            end
            total++;
            if (cnt[0] !== 16'((i <= 5) ? 5 - i : 0) || dn[0] !== (i == 5) ||
                run[0] !== (i < 5) || zer[0] !== (i >= 5)) begin
                bad++;
                $display("FAIL one_shot edge=T+%0d got cnt=%0d done=%b run=%b zero=%b want cnt=%0d done=%b run=%b zero=%b",
                         i, cnt[0], dn[0], run[0], zer[0], (i <= 5) ? 5 - i : 0, i == 5, i < 5, i >= 5);
            end
        end
    endtask

    task automatic test_prescale();
        ar = 1'b0;
        do_load(3);
        st = 1'b1;
        tick();
        st = 1'b0;
        $display("test_prescale: load 3, start");
        for (int i = 1; i <= 13; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (cnt[k] !== 16'(m_cnt[k]) || run[k] !== (m_st[k] == 1) ||
                    zer[k] !== (m_cnt[k] == 0) || dn[k] !== m_dn[k]) begin
                    bad++;
                    $display("FAIL prescale_model p=%0d cyc=%0d got cnt=%0d run=%b zero=%b done=%b want cnt=%0d run=%b zero=%b done=%b",
                             1 << k, cyc, cnt[k], run[k], zer[k], dn[k], m_cnt[k], m_st[k] == 1, m_cnt[k] == 0, m_dn[k]);
                end
            end
            total++;
            if (cnt[2] !== 16'((i < 12) ? 3 - i / 4 : 0) || dn[2] !== (i == 12)) begin
                bad++;
                $display("FAIL prescale4 edge=T+%0d got cnt=%0d done=%b want cnt=%0d done=%b",
                         i, cnt[2], dn[2], (i < 12) ? 3 - i / 4 : 0, i == 12);
            end
        end
    endtask

    task automatic test_auto_reload();
        ar = 1'b1;
        do_load(3);
        st = 1'b1;
        tick();
        st = 1'b0;
        $display("test_auto_reload: load 3, auto_reload, start");
        for (int i = 1; i <= 20; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (cnt[k] !== 16'(m_cnt[k]) || run[k] !== (m_st[k] == 1) ||
                    zer[k] !== (m_cnt[k] == 0) || dn[k] !== m_dn[k]) begin
                    bad++;
                    $display("FAIL auto_reload_model p=%0d cyc=%0d got cnt=%0d run=%b zero=%b done=%b want cnt=%0d run=%b zero=%b done=%b",
                             1 << k, cyc, cnt[k], run[k], zer[k], dn[k], m_cnt[k], m_st[k] == 1, m_cnt[k] == 0, m_dn[k]);
                end
            end
            total++;
            if (cnt[0] !== 16'(3 - i % 3) || dn[0] !== (i % 3 == 0) || zer[0] !== 1'b0) begin
                bad++;
                $display("FAIL auto_reload edge=T+%0d got cnt=%0d done=%b zero=%b want cnt=%0d done=%b zero=0",
                         i, cnt[0], dn[0], zer[0], 3 - i % 3, i % 3 == 0);
            end
        end
        ar = 1'b0;
    endtask

    task automatic test_pause_resume();
        ar = 1'b0;
        do_load(4);
        st = 1'b1;
        tick();
        st = 1'b0;
        $display("test_pause_resume: load 4, start, stop at T+3, resume at T+8");
        for (int e = 1; e <= 16; e++) begin
            sp = (e == 3);
            st = (e == 8);
            tick();
            sp = 1'b0;
            st = 1'b0;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (cnt[k] !== 16'(m_cnt[k]) || run[k] !== (m_st[k] == 1) ||
                    zer[k] !== (m_cnt[k] == 0) || dn[k] !== m_dn[k]) begin
                    bad++;
                    $display("FAIL pause_model p=%0d cyc=%0d got cnt=%0d run=%b zero=%b done=%b want cnt=%0d run=%b zero=%b done=%b",
                             1 << k, cyc, cnt[k], run[k], zer[k], dn[k], m_cnt[k], m_st[k] == 1, m_cnt[k] == 0, m_dn[k]);
                end
            end
            total++;
            if (dn[1] !== (e == 14) || (e >= 2 && e <= 8 && cnt[1] !== 16'd3) ||
                (e >= 3 && e <= 7 && run[1] !== 1'b0)) begin
                bad++;
                $display("FAIL pause2 edge=T+%0d got cnt=%0d run=%b done=%b want done=%b (cnt 3 held while paused)",
                         e, cnt[1], run[1], dn[1], e == 14);
            end
        end
    endtask

    task automatic test_edge_cases();
        ar = 1'b0;
        // start with count 0 is ignored
        do_load(0);
        st = 1'b1;
        tick();
        st = 1'b0;
        $display("test_edge_cases: start with count 0");
        for (int k = 0; k < 3; k++) begin
            total++;
            if (run[k] !== 1'b0 || run[k] !== (m_st[k] == 1)) begin
                bad++;
                $display("FAIL start_at_zero p=%0d got run=%b want run=0", 1 << k, run[k]);
            end
        end
        // load on the expiry edge
        do_load(2);
        st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        ld = 1'b1;
        lv = 16'd9;
        tick();
        ld = 1'b0;
        $display("test_edge_cases: load 9 on expiry edge");
        total++;
        if (cnt[0] !== 16'd9 || run[0] !== 1'b0 || dn[0] !== 1'b0 || cnt[0] !== 16'(m_cnt[0])) begin
            bad++;
            $display("FAIL load_on_expiry got cnt=%0d run=%b done=%b want cnt=9 run=0 done=0", cnt[0], run[0], dn[0]);
        end
        // stop on the expiry edge, then resume
        do_load(2);
        st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        sp = 1'b1;
        tick();
        sp = 1'b0;
        $display("test_edge_cases: stop on expiry edge");
        total++;
        if (cnt[0] !== 16'd1 || run[0] !== 1'b0 || dn[0] !== 1'b0) begin
            bad++;
            $display("FAIL stop_on_expiry got cnt=%0d run=%b done=%b want cnt=1 run=0 done=0", cnt[0], run[0], dn[0]);
        end
        st = 1'b1;
        tick();
        st = 1'b0;
        total++;
        if (cnt[0] !== 16'd1 || run[0] !== 1'b1 || dn[0] !== 1'b0) begin
            bad++;
            $display("FAIL resume_edge got cnt=%0d run=%b done=%b want cnt=1 run=1 done=0", cnt[0], run[0], dn[0]);
        end
        tick();
        total++;
        if (cnt[0] !== 16'd0 || run[0] !== 1'b0 || dn[0] !== 1'b1) begin
            bad++;
            $display("FAIL resume_expiry got cnt=%0d run=%b done=%b want cnt=0 run=0 done=1", cnt[0], run[0], dn[0]);
        end
        // start and stop together: stop wins
        do_load(3);
        st = 1'b1;
        sp = 1'b1;
        tick();
        st = 1'b0;
        sp = 1'b0;
        $display("test_edge_cases: start with stop");
        for (int k = 0; k < 3; k++) begin
            total++;
            if (run[k] !== 1'b0 || cnt[k] !== 16'd3) begin
                bad++;
                $display("FAIL start_stop p=%0d got run=%b cnt=%0d want run=0 cnt=3", 1 << k, run[k], cnt[k]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        ar = 1'b0;
        do_load(100);
        st = 1'b1;
        tick();
        st = 1'b0;
        $display("test_reset_mid_run: load 100, start, reset at 50");
        while (cnt[0] !== 16'd50 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (cnt[0] !== 16'd50 || n != 50) begin
            bad++;
            $display("FAIL reach_50 got cnt=%0d after %0d cycles want cnt=50 after 50", cnt[0], n);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({cnt[k], run[k], zer[k], dn[k]} !== {16'd0, 1'b0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL reset_mid_run p=%0d got cnt=%0d run=%b zero=%b done=%b want cnt=0 run=0 zero=1 done=0",
                         1 << k, cnt[k], run[k], zer[k], dn[k]);
            end
        end
        st = 1'b1;
        tick();
        st = 1'b0;
        total++;
        if (run[0] !== 1'b0) begin
            bad++;
            $display("FAIL start_after_reset got run=%b want run=0", run[0]);
        end
    endtask

    task automatic test_random();
        int nd = 0;
        $display("test_random: 4000 random cycles");
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 150 == 0);
            ld  = ($urandom % 24 == 0);
            lv  = 16'($urandom_range(0, 5));
            st  = ($urandom % 4 == 0);
            sp  = ($urandom % 12 == 0);
            if ($urandom % 10 == 0) ar = ~ar;
            tick();
            for (int k = 0; k < 3; k++) begin
                if (m_dn[k]) nd++;
                total++;
                if (cnt[k] !== 16'(m_cnt[k]) || run[k] !== (m_st[k] == 1) ||
                    zer[k] !== (m_cnt[k] == 0) || dn[k] !== m_dn[k]) begin
                    bad++;
                    $display("FAIL random_model p=%0d cyc=%0d got cnt=%0d run=%b zero=%b done=%b want cnt=%0d run=%b zero=%b done=%b",
                             1 << k, cyc, cnt[k], run[k], zer[k], dn[k], m_cnt[k], m_st[k] == 1, m_cnt[k] == 0, m_dn[k]);
                end
            end
        end
        rst = 1'b0; ld = 1'b0; st = 1'b0; sp = 1'b0; ar = 1'b0;
        $display("test_random: %0d expiries seen", nd);
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_prescale();
        test_auto_reload();
        test_pause_resume();
        test_edge_cases();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a clock prescaler. It counts from a programmed value to zero, signals expiry with a one-cycle `done` pulse, and can reload itself to run periodically. It is the decrementing counterpart of the free-running up-counter used in the counter tutorial. Other tutorial blocks use it for timeouts, periodic ticks and LED blink rates.

## Interface
- `WIDTH`, default 16: width of the count and load value.
- `PRESCALE`, default 1: clock cycles per decrement. Must be ≥1. The prescaler is ⌈log2(PRESCALE)⌉ bits wide, minimum 1.
- `clock`  in  1  single design clock; all state changes on the posedge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  strobe: latch `load_value` into both the count and the reload register.
- `load_value`  in  WIDTH  value captured on `load`.
- `start`  in  1  strobe: begin or resume counting.
- `stop`  in  1  strobe: pause counting.
- `auto_reload`  in  1  level; sampled at expiry.
- `count`  out  WIDTH  current count value.
- `running`  out  1  high while in state RUN.
- `zero`  out  1  combinational `count == 0`.
- `done`  out  1  registered one-cycle pulse on expiry.

## Operation
- Reset values: `count` = 0, reload register = 0, prescaler = 0, state = IDLE, `running` = 0, `done` = 0. `zero` is therefore 1.
- States:
  - IDLE: stopped, count is static.
  - RUN: decrementing.
  - PAUSE: stopped mid-count, prescaler phase retained.
- Input priority per edge: `reset` > `load` > `stop` > `start` > run/expiry logic.
- `load`, in any state:
  - count ← `load_value`, reload register ← `load_value`, prescaler ← 0.
  - State → IDLE. `done` = 0 that cycle.
- `stop`:
  - In RUN: state → PAUSE. No decrement that edge. Prescaler is held.
  - In IDLE or PAUSE: no effect.
- `start`:
  - In IDLE or PAUSE with count ≠ 0: state → RUN. The prescaler is cleared from IDLE and kept from PAUSE.
  - With count = 0: ignored, state unchanged.
  - In RUN: no effect.
- RUN, per edge:
  - If prescaler ≠ PRESCALE−1: prescaler + 1.
  - Otherwise: prescaler ← 0 and a decrement occurs.
- Decrement with count > 1: count − 1.
- Decrement with count = 1 (expiry): `done` ← 1 for exactly one cycle, then:
  - `auto_reload` = 1: count ← reload register, state stays RUN.
  - `auto_reload` = 0: count ← 0, state → IDLE.
- Arithmetic is unsigned, and count never wraps below 0.

## Timing
- Latency from `start` to RUN: `start` sampled at edge T, so `running` = 1 after T.
- First decrement lands at edge T + PRESCALE.
- One-shot timing with PRESCALE = P and loaded value N:
  - count reaches 0 at edge T + N·P.
  - `done` is high during the cycle following that edge, coincident with `zero` = 1 and `running` = 0.
- Auto-reload period: `done` pulses every N·P cycles. The count sequence is N, N−1, …, 1, N, …. `zero` never asserts.
- `done` is high for exactly one cycle per expiry and never on two consecutive cycles, except when N·P = 1 with auto-reload.
  - With N = 1 and P = 1, `done` stays high every cycle. This is legal.
- Pause/resume: each cycle spent in PAUSE extends the expiry time by exactly one cycle. The prescaler phase is preserved.
- Simultaneous events:
  - `load` + expiry: load wins, no `done`.
  - `stop` + expiry edge: stop wins, count stays at 1, no `done`.
  - `start` + `stop`: stop wins.
- `reset` mid-count: all outputs return to reset values at the next edge, and any pending `done` is cancelled.
- Changing `auto_reload` mid-count is legal. Only its value at the expiry edge matters.

## Test plan
- One-shot, PRESCALE = 1: reset, then load 5, then start at edge T.
  - count is 4, 3, 2, 1, 0 at edges T+1..T+5.
  - `done` is high for one cycle after T+5 only.
  - `running` = 0 and `zero` = 1 after T+5.
- Prescaler, PRESCALE = 4: load 3, then start at T.
  - Decrements occur at T+4, T+8 and T+12.
  - `done` is high after T+12.
  - Total: 12 cycles.
- Auto-reload, PRESCALE = 1: `auto_reload` = 1, load 3, start, run 20 cycles.
  - `done` pulses every 3 cycles.
  - count sequence is 2, 1, 3, 2, 1, 3….
  - `zero` stays 0 throughout.
- Pause/resume, PRESCALE = 2: load 4, start, pause for 5 cycles after the first decrement, then resume.
  - Expiry is 8 + 5 + 1 (the restart edge) cycles after the first start.
  - count holds at 3 during PAUSE.
- Edge cases:
  - start with count = 0 leaves `running` = 0.
  - `load` 9 on the expiry edge gives count = 9, IDLE, no `done`.
  - `stop` on the expiry edge gives count = 1, PAUSE, no `done`.
- Reset mid-run: load 100, start, assert `reset` at count 50.
  - Next cycle: count = 0, `running` = 0, `done` = 0.
  - A subsequent start is ignored.
